// File: rtl/ultratank_pkg.sv
// ultratank_pkg: Ultra Tank ROM region map, image size and ROM loader state types.
package ultratank_pkg;
  localparam int R0_BASE = 'h0000;
  localparam int R0_SIZE = 'h2000;
  localparam int R1_BASE = 'h2000;
  localparam int R1_SIZE = 'h0800;
  localparam int R2_BASE = 'h2800;
  localparam int R2_SIZE = 'h0800;
  localparam int R3_BASE = 'h3000;
  localparam int R3_SIZE = 'h0100;
  localparam int IMG_BYTES = 'h3100;
  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_HOLD, ST_RUN, ST_ERROR} rls_state_t;
  typedef logic [1:0] region_idx_t;
  function automatic logic [24:0] region_base(region_idx_t r);
    return r == 2'd3 ? 25'(R3_BASE) : r == 2'd2 ? 25'(R2_BASE) : r == 2'd1 ? 25'(R1_BASE) : 25'(R0_BASE);
  endfunction
endpackage

// File: rtl/rom_load_sequencer_if.sv
// rom_load_sequencer_if: HPS download port in, ROM write port out.
interface rom_load_sequencer_if #(parameter int ADDR_W = 16);
  logic              ioctl_download;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [3:0]        rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  modport master(output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, input rom_we, rom_addr, rom_data);
  modport slave(input ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, output rom_we, rom_addr, rom_data);
endinterface

// File: rtl/rom_region_decode.sv
// rom_region_decode: maps an image byte address to its ROM region strobe and region-local address.
module rom_region_decode
  import ultratank_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [24:0]       addr,
  output logic              hit,
  output logic [3:0]        onehot,
  output logic [ADDR_W-1:0] local_addr
);
  region_idx_t idx;
  always_comb begin
    hit = addr < 25'(IMG_BYTES);
    idx = addr < 25'(R0_BASE + R0_SIZE) ? 2'd0 :
          addr < 25'(R1_BASE + R1_SIZE) ? 2'd1 :
          addr < 25'(R2_BASE + R2_SIZE) ? 2'd2 : 2'd3;
    onehot = hit ? 4'b0001 << idx : 4'b0000;
    local_addr = ADDR_W'(addr - region_base(idx));
  end
endmodule

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: routes HPS download bytes to the ROM regions, validates the image
// and owns the core reset, releasing it a fixed hold time after a good load or a reset request.
module rom_load_sequencer
  import ultratank_pkg::*;
#(
  parameter int HOLD_CYCLES = 4096,
  parameter int ADDR_W      = 16
) (
  input  logic                clk_sys,
  input  logic                Reset_n,
  rom_load_sequencer_if.slave bus,
  input  logic                rst_req,
  output logic                core_reset_n,
  output logic                busy,
  output logic                dl_error
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  rls_state_t        state_q, state_d;
  logic              dl_q;
  logic [16:0]       cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [3:0]        we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              crn_q, crn_d, busy_q, busy_d, err_q, err_d;
  logic              hit, rise, fall, img_ok;
  logic [3:0]        onehot;
  logic [ADDR_W-1:0] local_addr;

  rom_region_decode #(.ADDR_W(ADDR_W)) u_decode (
    .addr       (bus.ioctl_addr),
    .hit        (hit),
    .onehot     (onehot),
    .local_addr (local_addr)
  );

  assign rise = bus.ioctl_download & ~dl_q;
  assign fall = ~bus.ioctl_download & dl_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    hold_d  = hold_q;
    err_d   = err_q;
    we_d    = 4'b0000;
    addr_d  = addr_q;
    data_d  = data_q;
    img_ok  = 1'b0;
    if (rise) begin
      state_d = ST_LOAD;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (bus.ioctl_wr) begin
            cnt_d  = (hit && !(&cnt_q)) ? cnt_q + 17'd1 : cnt_q;
            ovf_d  = ovf_q | ~hit;
            we_d   = onehot;
            addr_d = hit ? local_addr : addr_q;
            data_d = hit ? bus.ioctl_dout : data_q;
          end
          // a byte arriving with the falling download edge is counted before the size check
          if (fall) begin
            img_ok  = cnt_d == 17'(IMG_BYTES) && !ovf_d;
            state_d = img_ok ? ST_HOLD : ST_ERROR;
            err_d   = !img_ok;
            hold_d  = '0;
          end
        end
        ST_HOLD: begin
          hold_d  = rst_req ? '0 : hold_q + 1'b1;
          state_d = (!rst_req && hold_q == HOLD_LAST) ? ST_RUN : ST_HOLD;
        end
        ST_RUN: begin
          state_d = rst_req ? ST_HOLD : ST_RUN;
          hold_d  = '0;
        end
        default: state_d = state_q;
      endcase
    end
    crn_d  = state_d == ST_RUN;
    busy_d = state_d == ST_LOAD || state_d == ST_HOLD;
  end

  always_ff @(posedge clk_sys or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      dl_q    <= 1'b0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      hold_q  <= '0;
      we_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      crn_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q    <= bus.ioctl_download;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      hold_q  <= hold_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      crn_q   <= crn_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.rom_we    = we_q;
  assign bus.rom_addr  = addr_q;
  assign bus.rom_data  = data_q;
  assign core_reset_n  = crn_q;
  assign busy          = busy_q;
  assign dl_error      = err_q;
endmodule
